// File: rtl/ctr_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing a counter block's configuration bus; each grant is SETUP, STROBE, RECOVER.
// Define CTR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ctr_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 16,
    parameter int NUM_ROUTES = 16
) (
    input  logic                           busclk,
    input  logic                           busrst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [2*NUM_REQ-1:0]           req_adr,
    input  logic [8*NUM_REQ-1:0]           req_data,
    input  logic [WIDTH*NUM_REQ-1:0]       req_wide,
    input  logic [NUM_ROUTES*NUM_REQ-1:0]  req_route,
    output logic [NUM_REQ-1:0]             ack,
    output logic [7:0]                     rdata,
    output logic                           busy,
    output logic                           cb_cs,
    output logic                           cb_wr,
    output logic                           cb_rd,
    output logic [1:0]                     cb_adr,
    output logic [7:0]                     cb_data,
    output logic [WIDTH-1:0]               cb_wide,
    output logic [NUM_ROUTES-1:0]          cb_route,
    input  logic [7:0]                     cb_data_out
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = IDXW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETUP   = 2'd1;
    localparam logic [1:0] S_STROBE  = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [IDXW-1:0]       win_q;
    logic                  wr_q;
    logic [1:0]            adr_q;
    logic [7:0]            data_q;
    logic [WIDTH-1:0]      wide_q;
    logic [NUM_ROUTES-1:0] route_q;
    logic [7:0]            rdata_q;

    logic [IDXW-1:0] base;
    logic [IDXW-1:0] pick;
    logic            found;
    logic [CW-1:0]   cand;
    logic            grant;
    int              sel;

`ifdef CTR_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]   pick_inc;

    assign base     = ptr_q;
    assign pick_inc = {1'b0, pick} + CW'(1);
    assign ptr_d    = (pick_inc == CW'(NUM_REQ)) ? '0 : pick_inc[IDXW-1:0];

    always_ff @(posedge busclk or negedge busrst_n) begin
        if (!busrst_n) begin
            ptr_q <= '0;
        end else if (grant) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Search starts at base and wraps modulo NUM_REQ; the first active request wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, base} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && req[cand[IDXW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDXW-1:0];
            end
        end
    end

    assign grant = (state_q == S_IDLE) && found;
    assign sel   = int'(pick);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (found) state_d = S_SETUP;
            S_SETUP:   state_d = S_STROBE;
            S_STROBE:  state_d = S_RECOVER;
            default:   state_d = S_IDLE;
        endcase
    end

    // Bus fields are latched only at grant, so later requester changes are ignored.
    always_ff @(posedge busclk or negedge busrst_n) begin
        if (!busrst_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            wr_q    <= 1'b0;
            adr_q   <= '0;
            data_q  <= '0;
            wide_q  <= '0;
            route_q <= '0;
            rdata_q <= 8'hFF;
        end else begin
            state_q <= state_d;
            if (grant) begin
                win_q   <= pick;
                wr_q    <= req_wr[pick];
                adr_q   <= req_adr[2*sel +: 2];
                data_q  <= req_data[8*sel +: 8];
                wide_q  <= req_wide[WIDTH*sel +: WIDTH];
                route_q <= req_route[NUM_ROUTES*sel +: NUM_ROUTES];
            end
            if ((state_q == S_STROBE) && !wr_q) begin
                rdata_q <= cb_data_out;
            end
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign cb_cs    = (state_q == S_SETUP) || (state_q == S_STROBE);
    assign cb_wr    = (state_q == S_STROBE) && wr_q;
    assign cb_rd    = (state_q == S_STROBE) && !wr_q;
    assign busy     = (state_q != S_IDLE);
    assign cb_adr   = adr_q;
    assign cb_data  = data_q;
    assign cb_wide  = wide_q;
    assign cb_route = route_q;
    assign rdata    = rdata_q;

    always_comb begin
        ack = '0;
        if (state_q == S_RECOVER) begin
            ack[win_q] = 1'b1;
        end
    end

endmodule
